// File: rtl/seq_mult_4bit.sv
// ---------------------------------------------------------------------------
// seq_mult_4bit
//   Sequential unsigned 4x4 shift-and-add multiplier with an 8-bit product.
//   One RCA_4_bit instance forms each partial sum; one add-and-shift step is
//   performed per clock over exactly four RUN cycles.
//
// Ports (seq_mult_4bit):
//   clk      in   1  clock, all state updates on the rising edge
//   rst      in   1  synchronous active-high reset, highest priority
//   start    in   1  operation request, only sampled in IDLE
//   a        in   4  multiplicand, captured when start is accepted
//   b        in   4  multiplier, captured when start is accepted
//   busy     out  1  high while the multiply steps are running
//   done     out  1  one-cycle pulse when the product becomes valid
//   product  out  8  registered a*b, held until the next result
//
// Ports (RCA_4_bit):
//   a, b     in   4  addends
//   c_in     in   1  carry in
//   s        out  4  sum
//   c_out    out  1  carry out
// ---------------------------------------------------------------------------

module RCA_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [4:0] carry_s;

  // Ripple-carry chain of four full adders.
  always_comb begin
    carry_s    = 5'b00000;
    s          = 4'b0000;
    carry_s[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      s[i]         = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
    end
    c_out = carry_s[4];
  end

endmodule

module seq_mult_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] m_q, m_d;         // multiplicand
  logic [3:0] q_q, q_d;         // multiplier / product low half
  logic [3:0] a_q, a_d;         // accumulator / product high half
  logic [1:0] cnt_q, cnt_d;     // step counter
  logic [7:0] product_q, product_d;

  logic [3:0] rca_b_s;
  logic [3:0] rca_sum_s;
  logic       rca_co_s;
  logic       busy_s;
  logic       done_s;

  // The partial sum adds M only when the current multiplier LSB is set.
  assign rca_b_s = q_q[0] ? m_q : 4'b0000;

  RCA_4_bit u_rca (
    .a     (a_q),
    .b     (rca_b_s),
    .c_in  (1'b0),
    .s     (rca_sum_s),
    .c_out (rca_co_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on start, four RUN steps, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state only.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_q)
      S_IDLE:  begin busy_s = 1'b0; done_s = 1'b0; end
      S_RUN:   begin busy_s = 1'b1; done_s = 1'b0; end
      S_DONE:  begin busy_s = 1'b0; done_s = 1'b1; end
      default: begin busy_s = 1'b0; done_s = 1'b0; end
    endcase
  end

  assign busy    = busy_s;
  assign done    = done_s;
  assign product = product_q;

  // Datapath next-state: operand capture and the add-and-shift step.
  // The 9-bit {c_out, sum, Q} is shifted right by one, so the RCA carry lands
  // in A[3] and is never lost. The bit shifted into the carry position is
  // always zero, so no separate carry register is kept between steps.
  always_comb begin
    m_d       = m_q;
    q_d       = q_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d   = a;
          q_d   = b;
          a_d   = 4'b0000;
          cnt_d = 2'd0;
        end else begin
          m_d   = m_q;
          q_d   = q_q;
          a_d   = a_q;
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        a_d   = {rca_co_s, rca_sum_s[3:1]};
        q_d   = {rca_sum_s[0], q_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          product_d = {rca_co_s, rca_sum_s, q_q[3:1]};
        end else begin
          product_d = product_q;
        end
      end
      S_DONE: begin
        product_d = product_q;
      end
      default: begin
        product_d = product_q;
      end
    endcase
  end

  // Datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q       <= 4'b0000;
      q_q       <= 4'b0000;
      a_q       <= 4'b0000;
      cnt_q     <= 2'd0;
      product_q <= 8'h00;
    end else begin
      m_q       <= m_d;
      q_q       <= q_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_seq_mult_4bit.sv
// Scoreboard bench for seq_mult_4bit: stimulus pushes expected products,
// a negedge monitor pops and compares whenever done is presented.
module tb_seq_mult_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int held_exp = 0;
  int mon_exp  = 0;
  logic prev_done = 1'b0;

  seq_mult_4bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare product at each done pulse, and check it is held otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("product_at_done", int'(product), mon_exp);
          held_exp = mon_exp;
        end
        chk("done_single_cycle", int'(prev_done), 0);
      end else begin
        chk("product_held", int'(product), held_exp);
      end
      chk("busy_done_exclusive", int'(busy & done), 0);
    end
    prev_done = done;
  end

  // One full operation: accept edge, four busy cycles, one done cycle.
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input int exp);
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("op_busy", int'(busy), (i < 4) ? 1 : 0);
      chk("op_done", int'(done), (i == 4) ? 1 : 0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_product", int'(product), 0);

    // Basic and boundary products.
    run_op(4'd0, 4'd0, 0);
    run_op(4'd15, 4'd15, 225);
    // Back-to-back sequence; held value checked by the monitor.
    run_op(4'd4, 4'd12, 48);
    run_op(4'd11, 4'd6, 66);
    run_op(4'd5, 4'd4, 20);
    drain();

    // start held high: accepts at e0, e6, e12; operands disturbed mid-RUN.
    @(posedge clk); #1;
    start = 1'b1; a = 4'd3; b = 4'd7;
    exp_q.push_back(21); exp_q.push_back(21); exp_q.push_back(21);
    for (int i = 0; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin a = 4'd9; b = 4'd9; end
      if (i == 3) begin a = 4'd3; b = 4'd7; end
      if (i == 12) start = 1'b0;
      @(negedge clk);
      chk("cont_busy", int'(busy), ((i % 6) < 4) ? 1 : 0);
      chk("cont_done", int'(done), ((i % 6) == 4) ? 1 : 0);
    end
    drain();

    // start during DONE is ignored; accepted one cycle later in IDLE.
    @(posedge clk); #1;
    start = 1'b1; a = 4'd7; b = 4'd9;
    exp_q.push_back(63);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; a = 4'd2; b = 4'd2;
    exp_q.push_back(4);
    @(negedge clk);
    chk("ds_done", int'(done), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ds_ignored_busy", int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("ds_accepted_busy", int'(busy), 1);
    drain();

    // Reset in the second RUN cycle of 13*13 discards the operation.
    @(posedge clk); #1;
    start = 1'b1; a = 4'd13; b = 4'd13;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    held_exp = 0;
    @(negedge clk);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_product", int'(product), 0);
    run_op(4'd2, 4'd3, 6);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
